// File: rtl/door_animation_param_if.sv
// Door animation bus: open/obstruct requests toward the controller, LED pattern and status back.
// Width of leds and position follows N_LEDS so the interface matches the controller parameters.
interface door_animation_param_if #(
  parameter int N_LEDS = 10
) ();
  localparam int H  = N_LEDS / 2;
  localparam int PW = $clog2(H + 1);

  logic              open_btn;
  logic              obstruct;
  logic [N_LEDS-1:0] leds;
  logic [PW-1:0]     position;
  logic              busy;
  logic              door_open;
  logic              door_cycle_complete;

  modport master (
    output open_btn, obstruct,
    input  leds, position, busy, door_open, door_cycle_complete
  );

  modport slave (
    input  open_btn, obstruct,
    output leds, position, busy, door_open, door_cycle_complete
  );
endinterface

// File: rtl/door_animation_param.sv
// Two-leaf sliding door LED animation: opens from the centre, holds, closes, pulses on completion.
// Optional obstruction re-open is enabled by defining DOOR_OBSTRUCT_EN.
module door_animation_param #(
  parameter int N_LEDS     = 10,
  parameter int STEP_TICKS = 4,
  parameter int HOLD_STEPS = 1
) (
  input logic                    clk,
  input logic                    rst_a_p,
  door_animation_param_if.slave  door
);
  localparam int H  = N_LEDS / 2;
  localparam int PW = $clog2(H + 1);
  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PW-1:0] POS_FULL  = PW'(H);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam bit            H_IS_ONE  = (H == 1);

  typedef enum logic [1:0] {IDLE, OPENING, HOLD, CLOSING} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     pos, pos_next;
  logic [TW-1:0]     tick, tick_next;
  logic [HW-1:0]     hold_cnt, hold_next;
  logic              complete_next;
  logic              step;
  logic [N_LEDS-1:0] leds_q;
  logic              busy_q, open_q, done_q;

  // Panels stay lit outside the centre gap of 2k LEDs.
  function automatic logic [N_LEDS-1:0] pattern(input logic [PW-1:0] k);
    logic [N_LEDS-1:0] p;
    for (int i = 0; i < N_LEDS; i++) begin
      p[i] = (i < H - int'(k)) || (i >= H + int'(k));
    end
    return p;
  endfunction

  assign step = (tick == TICK_LAST);

  always_comb begin
    state_next    = state;
    pos_next      = pos;
    tick_next     = step ? '0 : tick + 1'b1;
    hold_next     = hold_cnt;
    complete_next = 1'b0;
    case (state)
      IDLE: begin
        tick_next = '0;
        if (door.open_btn) begin
          pos_next   = PW'(1);
          hold_next  = '0;
          state_next = H_IS_ONE ? HOLD : OPENING;
        end
      end
      OPENING: begin
        if (step) begin
          pos_next = pos + 1'b1;
          if (pos + 1'b1 == POS_FULL) begin
            state_next = HOLD;
            hold_next  = '0;
          end
        end
      end
      HOLD: begin
`ifdef DOOR_OBSTRUCT_EN
        if (door.obstruct) begin
          hold_next = '0;
        end else
`endif
        if (step) begin
          if (hold_cnt == HOLD_LAST) begin
            pos_next = POS_FULL - 1'b1;
            if (H_IS_ONE) begin
              state_next    = IDLE;
              complete_next = 1'b1;
              tick_next     = '0;
            end else begin
              state_next = CLOSING;
            end
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end
      CLOSING: begin
`ifdef DOOR_OBSTRUCT_EN
        // Obstruction beats a coinciding step: the door re-opens from where it is.
        if (door.obstruct) begin
          state_next = OPENING;
          tick_next  = '0;
        end else
`endif
        if (step) begin
          pos_next = pos - 1'b1;
          if (pos == PW'(1)) begin
            state_next    = IDLE;
            complete_next = 1'b1;
            tick_next     = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      state    <= IDLE;
      pos      <= '0;
      tick     <= '0;
      hold_cnt <= '0;
      leds_q   <= '1;
      busy_q   <= 1'b0;
      open_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      pos      <= pos_next;
      tick     <= tick_next;
      hold_cnt <= hold_next;
      leds_q   <= pattern(pos_next);
      busy_q   <= (state_next != IDLE);
      open_q   <= (pos_next == POS_FULL);
      done_q   <= complete_next;
    end
  end

`ifndef DOOR_OBSTRUCT_EN
  logic unused_obstruct;
  assign unused_obstruct = door.obstruct;
`endif

  assign door.leds                = leds_q;
  assign door.position            = pos;
  assign door.busy                = busy_q;
  assign door.door_open           = open_q;
  assign door.door_cycle_complete = done_q;
endmodule

// File: tb/tb_door_animation_param.sv
// Directed bench for door_animation_param: defaults, a wide single-tick build and an H=1 build.
// Expectations follow DOOR_OBSTRUCT_EN so the bench fits either build.
module tb_door_animation_param;
  logic clk = 1'b0;
  logic rst_a_p;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  door_animation_param_if #(.N_LEDS(10)) if_a ();
  door_animation_param_if #(.N_LEDS(16)) if_b ();
  door_animation_param_if #(.N_LEDS(2))  if_c ();

  door_animation_param #(.N_LEDS(10), .STEP_TICKS(4), .HOLD_STEPS(1)) dut_a (
    .clk(clk), .rst_a_p(rst_a_p), .door(if_a));
  door_animation_param #(.N_LEDS(16), .STEP_TICKS(1), .HOLD_STEPS(3)) dut_b (
    .clk(clk), .rst_a_p(rst_a_p), .door(if_b));
  door_animation_param #(.N_LEDS(2), .STEP_TICKS(2), .HOLD_STEPS(2)) dut_c (
    .clk(clk), .rst_a_p(rst_a_p), .door(if_c));

  // Default-build LED patterns indexed by opening level.
  logic [9:0] led10 [6] = '{10'b1111111111, 10'b1111001111, 10'b1110000111,
                            10'b1100000011, 10'b1000000001, 10'b0000000000};
  int seq10 [10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};

  function automatic logic [15:0] ref_leds16(input int k);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = !((i >= 8 - k) && (i < 8 + k));
    return p;
  endfunction

  task automatic pulse_open_a();
    @(negedge clk) if_a.open_btn = 1'b1;
    @(negedge clk) if_a.open_btn = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got_a, exp_a;
    logic [22:0] got_b, exp_b;
    logic [5:0]  got_c, exp_c;
    rst_a_p = 1'b1;
    if_a.open_btn = 0; if_a.obstruct = 0;
    if_b.open_btn = 0; if_b.obstruct = 0;
    if_c.open_btn = 0; if_c.obstruct = 0;
    repeat (2) @(negedge clk);
    got_a = {if_a.position, if_a.leds, if_a.busy, if_a.door_open, if_a.door_cycle_complete};
    exp_a = {3'd0, 10'h3ff, 3'b000};
    got_b = {if_b.position, if_b.leds, if_b.busy, if_b.door_open, if_b.door_cycle_complete};
    exp_b = {4'd0, 16'hffff, 3'b000};
    got_c = {if_c.position, if_c.leds, if_c.busy, if_c.door_open, if_c.door_cycle_complete};
    exp_c = {1'b0, 2'b11, 3'b000};
    vectors += 3;
    if (got_a !== exp_a) begin miscompares++; $display("[TB] FAIL reset_a got=%b want=%b", got_a, exp_a); end
    if (got_b !== exp_b) begin miscompares++; $display("[TB] FAIL reset_b got=%b want=%b", got_b, exp_b); end
    if (got_c !== exp_c) begin miscompares++; $display("[TB] FAIL reset_c got=%b want=%b", got_c, exp_c); end
    rst_a_p = 1'b0;
  endtask

  task automatic test_default_cycle(input string tag);
    logic [15:0] got, exp;
    int p, pulses;
    pulses = 0;
    pulse_open_a();
    for (int n = 0; n <= 40; n++) begin
      p   = (n <= 36) ? seq10[n / 4] : 0;
      exp = {3'(p), led10[p], 1'(n < 36), 1'(p == 5), 1'(n == 36)};
      got = {if_a.position, if_a.leds, if_a.busy, if_a.door_open, if_a.door_cycle_complete};
      if (if_a.door_cycle_complete === 1'b1) pulses++;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s n=%0d got=%b want=%b", tag, n, got, exp);
      end
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("[TB] FAIL %s_pulses got=%0d want=1", tag, pulses); end
  endtask

  task automatic test_reset_mid_open();
    logic [15:0] got, exp;
    pulse_open_a();
    repeat (8) @(negedge clk);
    vectors++;
    if (if_a.position !== 3'd3) begin
      miscompares++; $display("[TB] FAIL rst_mid_pos got=%0d want=3", if_a.position);
    end
    rst_a_p = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (n == 2) rst_a_p = 1'b0;
      got = {if_a.position, if_a.leds, if_a.busy, if_a.door_open, if_a.door_cycle_complete};
      exp = {3'd0, 10'h3ff, 3'b000};
      vectors++;
      if (got !== exp) begin miscompares++; $display("[TB] FAIL rst_mid n=%0d got=%b want=%b", n, got, exp); end
    end
    @(negedge clk);
    got = {if_a.position, if_a.leds, if_a.busy, if_a.door_open, if_a.door_cycle_complete};
    vectors++;
    if (got !== exp) begin miscompares++; $display("[TB] FAIL rst_mid_after got=%b want=%b", got, exp); end
    test_default_cycle("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [15:0] got, exp;
    int m, p, pulses;
    pulses = 0;
    @(negedge clk) if_a.open_btn = 1'b1;
    @(negedge clk);
    for (int n = 0; n <= 74; n++) begin
      if (n == 73) if_a.open_btn = 1'b0;
      m   = (n <= 36) ? n : n - 37;
      p   = (m <= 36) ? seq10[m / 4] : 0;
      exp = {3'(p), led10[p], 1'(m < 36), 1'(p == 5), 1'(m == 36)};
      got = {if_a.position, if_a.leds, if_a.busy, if_a.door_open, if_a.door_cycle_complete};
      if (if_a.door_cycle_complete === 1'b1) pulses++;
      vectors++;
      if (got !== exp) begin miscompares++; $display("[TB] FAIL b2b n=%0d got=%b want=%b", n, got, exp); end
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 2) begin miscompares++; $display("[TB] FAIL b2b_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_obstruct();
    logic [15:0] got, exp;
    int p, done_n, pulses, idx;
    pulses = 0;
`ifdef DOOR_OBSTRUCT_EN
    done_n = 62;
`else
    done_n = 36;
`endif
    pulse_open_a();
    for (int n = 0; n <= 70; n++) begin
`ifdef DOOR_OBSTRUCT_EN
      if (n < 30) p = seq10[n / 4];
      else if (n < 34) p = 2;
      else begin
        idx = (n - 34) / 4 + 2;
        p   = (idx > 9) ? 0 : seq10[idx];
      end
`else
      p = (n <= 36) ? seq10[n / 4] : 0;
`endif
      exp = {3'(p), led10[p], 1'(n < done_n), 1'(p == 5), 1'(n == done_n)};
      got = {if_a.position, if_a.leds, if_a.busy, if_a.door_open, if_a.door_cycle_complete};
      if (if_a.door_cycle_complete === 1'b1) pulses++;
      vectors++;
      if (got !== exp) begin miscompares++; $display("[TB] FAIL obstruct n=%0d got=%b want=%b", n, got, exp); end
      if (n == 29) if_a.obstruct = 1'b1;
      if (n == 30) if_a.obstruct = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("[TB] FAIL obstruct_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_wide_fast();
    logic [22:0] got, exp;
    int p, open_cycles;
    open_cycles = 0;
    @(negedge clk) if_b.open_btn = 1'b1;
    @(negedge clk) if_b.open_btn = 1'b0;
    for (int n = 0; n <= 19; n++) begin
      if (n <= 7) p = n + 1;
      else if (n <= 9) p = 8;
      else p = (n >= 17) ? 0 : 17 - n;
      exp = {4'(p), ref_leds16(p), 1'(n < 17), 1'(p == 8), 1'(n == 17)};
      got = {if_b.position, if_b.leds, if_b.busy, if_b.door_open, if_b.door_cycle_complete};
      if (if_b.door_open === 1'b1) open_cycles++;
      vectors++;
      if (got !== exp) begin miscompares++; $display("[TB] FAIL wide n=%0d got=%b want=%b", n, got, exp); end
      @(negedge clk);
    end
    vectors++;
    if (open_cycles !== 3) begin miscompares++; $display("[TB] FAIL wide_open_cycles got=%0d want=3", open_cycles); end
  endtask

  task automatic test_single_level();
    logic [5:0] got, exp;
    int p;
    @(negedge clk) if_c.open_btn = 1'b1;
    @(negedge clk) if_c.open_btn = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      p   = (n < 4) ? 1 : 0;
      exp = {1'(p), (p == 1) ? 2'b00 : 2'b11, 1'(n < 4), 1'(p == 1), 1'(n == 4)};
      got = {if_c.position, if_c.leds, if_c.busy, if_c.door_open, if_c.door_cycle_complete};
      vectors++;
      if (got !== exp) begin miscompares++; $display("[TB] FAIL h1 n=%0d got=%b want=%b", n, got, exp); end
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] door_animation_param bench start");
    test_reset();
    test_default_cycle("default");
    test_reset_mid_open();
    test_back_to_back();
    test_obstruct();
    test_wide_fast();
    test_single_level();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/door_animation_param.md
# door_animation_param

Parametrised door-animation controller: drives a row of `N_LEDS` indicator LEDs as a two-leaf sliding door that opens from the centre outward, holds open, then closes. It generalises the fixed 10-LED, fixed-rate animation in width, step rate and hold time. It replaces the external clock divider with an internal step-tick counter. Optionally it re-opens the door on an obstruction sensor. It sits between the debounced push-button logic and the board LED pins, and reports completion to the access-control sequencer.

## Interface
Parameters:
- `N_LEDS`, 10: LED count; must be even and ≥2; `H = N_LEDS/2` opening levels.
- `STEP_TICKS`, 4: `clk` cycles per animation step; must be ≥1.
- `HOLD_STEPS`, 1: steps the door stays fully open; must be ≥1.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst_a_p`  in  1: reset, synchronous, active-high.
- `open_btn`  in  1: open request, level-sampled, already synchronised and debounced.
- `obstruct`  in  1: obstruction sensor, synchronised. Used only with `DOOR_OBSTRUCT_EN`.
- `leds`  out  `N_LEDS`: door pattern. 1 = panel lit, 0 = gap.
- `position`  out  `$clog2(H+1)`: current opening level, 0..H.
- `busy`  out  1: high whenever the state is not IDLE.
- `door_open`  out  1: high while `position == H`.
- `door_cycle_complete`  out  1: one-cycle pulse when the door returns to closed.

## Operation
- `leds` is a pure function of `position` k. The centre 2k LEDs, bits `H-k` .. `H+k-1`, are 0; all other bits are 1.
  - k=0: all ones.
  - k=H: all zeros.
- FSM states are IDLE, OPENING, HOLD and CLOSING. A step counter `tick` counts 0..`STEP_TICKS-1`; a "step" is `tick == STEP_TICKS-1`.
- IDLE: `position=0`, `tick` held at 0. If `open_btn=1` at an edge, go to OPENING with `position←1` and `tick←0`.
- OPENING: on each step, `position++`. When `position` becomes H, go to HOLD with the hold counter ←0.
  - For H=1, IDLE goes to HOLD directly with `position=1`.
- HOLD: on each step, the hold counter increments. After `HOLD_STEPS` steps, go to CLOSING with `position←H-1`.
  - For H=1, `position←0`, the FSM enters IDLE and pulses complete.
- CLOSING: on each step, `position--`. When it becomes 0, go to IDLE and assert `door_cycle_complete` for exactly that one cycle.
- `open_btn` is ignored outside IDLE.
- A new open can be accepted at the edge after the completion pulse at the earliest, so a closed pattern shows for at least one cycle.
- All outputs are registered. Reset values: `leds` all ones, `position=0`, `busy=0`, `door_open=0`, `door_cycle_complete=0`, state IDLE, counters 0.
- Reset mid-animation: the next edge forces all reset values. No completion pulse is generated.

## Timing
- Open accepted at edge E0: `position=1` and `busy=1` are visible after E0.
- `position=k` is reached at E0 + (k-1)·`STEP_TICKS`.
- The fully-closed edge is E0 + (2H-2+`HOLD_STEPS`)·`STEP_TICKS`. The complete pulse and `busy=0` appear on that edge.
- Defaults (H=5, T=4, hold 1): positions 1,2,3,4,5,4,3,2,1,0 with one change every 4 cycles. Complete arrives 36 cycles after E0.
- `door_open` is high for exactly `HOLD_STEPS`·`STEP_TICKS` cycles per cycle (without obstruction).
- With `STEP_TICKS=1`, `position` changes every cycle.

## Configuration
- `DOOR_OBSTRUCT_EN` defined:
  - In CLOSING, `obstruct=1` at an edge moves the FSM to OPENING, keeps `position` unchanged and reloads `tick←0`. `position` then increments on the next step.
  - In HOLD, `obstruct=1` resets the hold counter to 0, which extends the open time.
  - If `obstruct` and a step coincide in CLOSING, obstruct wins: no decrement occurs.
  - No completion pulse is generated until the door actually reaches 0.
- `DOOR_OBSTRUCT_EN` undefined: `obstruct` is ignored entirely, and no obstruction logic or hold-counter reset is synthesised.

## Test plan
- Defaults, reset, then `open_btn` pulse for 1 cycle → `leds` sequence 1111001111, 1110000111, 1100000011, 1000000001, 0000000000, then mirror back to 1111111111 at 4-cycle spacing. Single complete pulse 36 cycles after acceptance.
- `open_btn` held high continuously → back-to-back cycles. Exactly one closed cycle with `busy=0` between them, one complete pulse each. Presses during an animation have no effect.
- `N_LEDS=16`, `STEP_TICKS=1`, `HOLD_STEPS=3` → `position` 1..8, `door_open` high for 3 cycles, 0 at 17 cycles after acceptance.
- `rst_a_p` asserted at `position=3` while OPENING → next edge `leds`=all ones, `position=0`, `busy=0`, no complete pulse. A new open then works normally.
- With `DOOR_OBSTRUCT_EN`, `obstruct` high for 1 cycle when CLOSING at `position=2` → `position` stays 2, then 3,4,5, HOLD, and a full close. Complete pulses only once.
- Without `DOOR_OBSTRUCT_EN`, the same stimulus → timing is identical to the unobstructed default run.
